// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared select codes, FSM encoding and helpers for forwarding/hazard control
package fwd_hazard_ctrl_pkg;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_MEMWB = 2'b01;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_compare.sv
// rtl/fwd_compare.sv - single-operand forwarding select from EX/MEM producer tracking
module fwd_compare
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic [1:0]            sel
);

    logic ex_hit;
    logic mem_hit;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value
    always_comb begin
        ex_hit  = use_rs & ex_valid & ex_reg_write & (ex_rd != '0) & (ex_rd == rs);
        mem_hit = use_rs & mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);
        sel     = SEL_RF;
        if (ex_hit) begin
            sel = SEL_EXMEM;
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX/MEM/WB tracking, load-use stall FSM and registered forwarding selects
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  ex_bubble,
    output logic [15:0]           stall_count
);

    logic                  ex_valid_q,  ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,     ex_rd_d;
    logic                  ex_rw_q,     ex_rw_d;
    logic                  ex_mr_q,     ex_mr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,    mem_rd_d;
    logic                  mem_rw_q,    mem_rw_d;
    logic                  mem_mr_q,    mem_mr_d;
    logic                  wb_valid_q,  wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,     wb_rd_d;
    logic                  wb_rw_q,     wb_rw_d;
    logic                  wb_mr_q,     wb_mr_d;
    fsm_state_t            state_q,     state_d;
    logic [1:0]            fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0]            fwd_b_sel_q, fwd_b_sel_d;
    logic                  ex_bubble_q, ex_bubble_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       ex_load_prod;
    logic       load_use;
    logic       stall_c;
    logic       bubble_in;
    logic       unused_wb;

    fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_a (
        .rs           (id_rs1),
        .use_rs       (id_use_rs1),
        .ex_valid     (ex_valid_q),
        .ex_reg_write (ex_rw_q),
        .ex_rd        (ex_rd_q),
        .mem_valid    (mem_valid_q),
        .mem_reg_write(mem_rw_q),
        .mem_rd       (mem_rd_q),
        .sel          (sel_a)
    );

    fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_b (
        .rs           (id_rs2),
        .use_rs       (id_use_rs2),
        .ex_valid     (ex_valid_q),
        .ex_reg_write (ex_rw_q),
        .ex_rd        (ex_rd_q),
        .mem_valid    (mem_valid_q),
        .mem_reg_write(mem_rw_q),
        .mem_rd       (mem_rd_q),
        .sel          (sel_b)
    );

    // A load in EX cannot feed ID's consumer yet; one bubble lets it reach MEM
    always_comb begin
        ex_load_prod = ex_valid_q & ex_rw_q & ex_mr_q & (ex_rd_q != '0);
        load_use     = ex_load_prod &
                       ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                        (id_use_rs2 & (id_rs2 == ex_rd_q)));
        stall_c      = id_valid & ~flush & (state_q == ST_RUN) & load_use;
        bubble_in    = stall_c | flush;
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_rw_d     = ex_rw_q;
        ex_mr_d     = ex_mr_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_rw_d    = mem_rw_q;
        mem_mr_d    = mem_mr_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = wb_rw_q;
        wb_mr_d     = wb_mr_q;
        state_d     = state_q;
        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;
        ex_bubble_d = ex_bubble_q;
        stall_cnt_d = stall_cnt_q;
        if (enable) begin
            wb_valid_d  = mem_valid_q;
            wb_rd_d     = mem_rd_q;
            wb_rw_d     = mem_rw_q;
            wb_mr_d     = mem_mr_q;
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_rw_d    = ex_rw_q;
            mem_mr_d    = ex_mr_q;
            if (bubble_in) begin
                ex_valid_d = 1'b0;
                ex_rd_d    = '0;
                ex_rw_d    = 1'b0;
                ex_mr_d    = 1'b0;
            end else begin
                ex_valid_d = id_valid;
                ex_rd_d    = id_rd;
                ex_rw_d    = id_reg_write;
                ex_mr_d    = id_mem_read;
            end
            fwd_a_sel_d = (bubble_in | ~id_valid) ? SEL_RF : sel_a;
            fwd_b_sel_d = (bubble_in | ~id_valid) ? SEL_RF : sel_b;
            ex_bubble_d = bubble_in;
            // STALL always lasts exactly one enabled edge; flush lands here too
            state_d     = stall_c ? ST_STALL : ST_RUN;
            if (stall_c) begin
                stall_cnt_d = sat_inc16(stall_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            wb_mr_q     <= 1'b0;
            state_q     <= ST_RUN;
            fwd_a_sel_q <= SEL_RF;
            fwd_b_sel_q <= SEL_RF;
            ex_bubble_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            mem_mr_q    <= mem_mr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            wb_mr_q     <= wb_mr_d;
            state_q     <= state_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            ex_bubble_q <= ex_bubble_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // WB is tracked for completeness of the stage model; no current consumer reads it
    assign unused_wb = ^{wb_valid_q, wb_rd_q, wb_rw_q, wb_mr_q};

    assign stall       = stall_c;
    assign fwd_a_sel   = fwd_a_sel_q;
    assign fwd_b_sel   = fwd_b_sel_q;
    assign ex_bubble   = ex_bubble_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - table, directed and randomized checks of fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;

    logic          clk;
    logic          arst_n;
    logic          enable;
    logic          flush;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          stall;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          ex_bubble;
    logic [15:0]   stall_count;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.REG_ADDR_W(AW)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .stall       (stall),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .ex_bubble   (ex_bubble),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit en; bit fl; bit iv;
        int rs1; int rs2; bit u1; bit u2;
        int rd; bit rw; bit mr;
        bit e_stall; int e_a; int e_b; bit e_bub; int e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit en, bit fl, bit iv, int rs1, int rs2, bit u1, bit u2,
                                int rd, bit rw, bit mr,
                                bit e_stall, int e_a, int e_b, bit e_bub, int e_cnt);
        vec_t v;
        v.en = en; v.fl = fl; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.mr = mr;
        v.e_stall = e_stall; v.e_a = e_a; v.e_b = e_b; v.e_bub = e_bub; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic vec_t nop(int cnt);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        enable       = v.en;
        flush        = v.fl;
        id_valid     = v.iv;
        id_rs1       = v.rs1[AW-1:0];
        id_rs2       = v.rs2[AW-1:0];
        id_use_rs1   = v.u1;
        id_use_rs2   = v.u2;
        id_rd        = v.rd[AW-1:0];
        id_reg_write = v.rw;
        id_mem_read  = v.mr;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, ".stall"}, int'(stall), int'(v.e_stall));
        @(posedge clk);
        #1;
        chk({tag, ".fwd_a"}, int'(fwd_a_sel), v.e_a);
        chk({tag, ".fwd_b"}, int'(fwd_b_sel), v.e_b);
        chk({tag, ".bubble"}, int'(ex_bubble), int'(v.e_bub));
        chk({tag, ".count"}, int'(stall_count), v.e_cnt);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".stall"}, int'(stall), 0);
        chk({tag, ".fwd_a"}, int'(fwd_a_sel), 0);
        chk({tag, ".fwd_b"}, int'(fwd_b_sel), 0);
        chk({tag, ".bubble"}, int'(ex_bubble), 0);
        chk({tag, ".count"}, int'(stall_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        drive(nop(0));
        #1;
        check_reset_values("reset");
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Reference model: stages as a 3-entry array (EX, MEM, WB)
    typedef struct { bit v; int rd; bit rw; bit mr; } stg_t;
    stg_t mp[3];
    bit   m_held;
    int   m_cnt;

    function automatic bit producer(stg_t s);
        return s.v && s.rw && (s.rd != 0);
    endfunction

    function automatic int pick(int rs, bit u);
        if (!u) return 0;
        if (producer(mp[0]) && mp[0].rd == rs) return 2;
        if (producer(mp[1]) && mp[1].rd == rs) return 1;
        return 0;
    endfunction

    initial begin
        vec_t v;
        vec_t dep;
        vec_t r;
        string tag;
        bit    exp_stall;
        bit    bub;

        arst_n = 1'b0;
        drive(nop(0));
        #2;
        check_reset_values("init");
        @(negedge clk);
        arst_n = 1'b1;

        // back-to-back ALU forward from EX/MEM
        vecs.push_back(mk(1,0,1, 1,2,1,1, 5,1,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,1, 5,1,1,1, 6,1,0, 0,2,0,0,0));
        vecs.push_back(nop(0)); vecs.push_back(nop(0)); vecs.push_back(nop(0));
        // one gap: forward from MEM/WB
        vecs.push_back(mk(1,0,1, 1,2,1,1, 5,1,0, 0,0,0,0,0));
        vecs.push_back(nop(0));
        vecs.push_back(mk(1,0,1, 1,5,1,1, 7,1,0, 0,0,1,0,0));
        vecs.push_back(nop(0)); vecs.push_back(nop(0)); vecs.push_back(nop(0));
        // load-use: one stall, bubble, then MEM/WB forward on both
        vecs.push_back(mk(1,0,1, 1,0,1,0, 5,1,1, 0,0,0,0,0));
        vecs.push_back(mk(1,0,1, 5,5,1,1, 6,1,0, 1,0,0,1,1));
        vecs.push_back(mk(1,0,1, 5,5,1,1, 6,1,0, 0,1,1,0,1));
        vecs.push_back(nop(1)); vecs.push_back(nop(1)); vecs.push_back(nop(1));
        // x0 never forwards
        vecs.push_back(mk(1,0,1, 1,2,1,1, 0,1,0, 0,0,0,0,1));
        vecs.push_back(mk(1,0,1, 0,0,1,1, 6,1,0, 0,0,0,0,1));
        vecs.push_back(nop(1)); vecs.push_back(nop(1)); vecs.push_back(nop(1));
        // EX match beats MEM match
        vecs.push_back(mk(1,0,1, 1,2,1,1, 5,1,0, 0,0,0,0,1));
        vecs.push_back(mk(1,0,1, 1,2,1,1, 5,1,0, 0,0,0,0,1));
        vecs.push_back(mk(1,0,1, 5,5,1,1, 6,1,0, 0,2,2,0,1));
        vecs.push_back(nop(1)); vecs.push_back(nop(1)); vecs.push_back(nop(1));
        // flush overrides load-use stall
        vecs.push_back(mk(1,0,1, 1,0,1,0, 5,1,1, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1, 5,5,1,1, 6,1,0, 0,0,0,1,1));
        vecs.push_back(nop(1));
        // unused source does not trigger a load-use stall
        vecs.push_back(mk(1,0,1, 1,0,1,0, 5,1,1, 0,0,0,0,1));
        vecs.push_back(mk(1,0,1, 1,5,1,0, 6,1,0, 0,0,0,0,1));
        vecs.push_back(nop(1)); vecs.push_back(nop(1));

        for (int i = 0; i < vecs.size(); i++) begin
            $sformat(tag, "vec%0d", i);
            run_vec(vecs[i], tag);
        end

        // freeze before and during a stall, then reset mid-stall
        run_vec(mk(1,0,1, 1,0,1,0, 5,1,1, 0,0,0,0,1), "frz.load");
        dep = mk(0,0,1, 5,5,1,1, 6,1,0, 1,0,0,0,1);
        for (int i = 0; i < 3; i++) run_vec(dep, "frz.pre");
        dep.en = 1; dep.e_bub = 1; dep.e_cnt = 2;
        run_vec(dep, "frz.stall");
        dep.en = 0; dep.e_stall = 0;
        for (int i = 0; i < 3; i++) run_vec(dep, "frz.held");
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        arst_n = 1'b1;
        run_vec(mk(1,0,1, 5,5,1,1, 6,1,0, 0,0,0,0,0), "postrst");

        // randomized run against the array model
        do_reset();
        for (int k = 0; k < 3; k++) mp[k] = '{1'b0, 0, 1'b0, 1'b0};
        m_held = 1'b0;
        m_cnt  = 0;
        for (int n = 0; n < 3000; n++) begin
            r.en  = ($urandom_range(0, 9) != 0);
            r.fl  = ($urandom_range(0, 9) == 0);
            r.iv  = ($urandom_range(0, 4) != 0);
            r.rs1 = $urandom_range(0, 3);
            r.rs2 = $urandom_range(0, 3);
            r.u1  = ($urandom_range(0, 3) != 0);
            r.u2  = ($urandom_range(0, 2) != 0);
            r.rd  = $urandom_range(0, 3);
            r.rw  = ($urandom_range(0, 3) != 0);
            r.mr  = ($urandom_range(0, 2) == 0);
            exp_stall = r.iv && !r.fl && !m_held && producer(mp[0]) && mp[0].mr &&
                        ((r.u1 && r.rs1 == mp[0].rd) || (r.u2 && r.rs2 == mp[0].rd));
            r.e_stall = exp_stall;
            if (r.en) begin
                bub = exp_stall || r.fl;
                r.e_a = (bub || !r.iv) ? 0 : pick(r.rs1, r.u1);
                r.e_b = (bub || !r.iv) ? 0 : pick(r.rs2, r.u2);
                r.e_bub = bub;
                mp[2] = mp[1];
                mp[1] = mp[0];
                mp[0] = bub ? '{1'b0, 0, 1'b0, 1'b0} : '{r.iv, r.rd, r.rw, r.mr};
                m_held = exp_stall;
                if (exp_stall && m_cnt < 65535) m_cnt++;
                r.e_cnt = m_cnt;
            end else begin
                r.e_a   = int'(fwd_a_sel);
                r.e_b   = int'(fwd_b_sel);
                r.e_bub = ex_bubble;
                r.e_cnt = m_cnt;
            end
            run_vec(r, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-address width.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: arst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: enable  in  1  pipeline advance; 0 freezes all state.
REQ-005 Port: flush  in  1  kill the instruction leaving ID (branch taken).
REQ-006 Port: id_valid  in  1  ID holds a real instruction.
REQ-007 Port: id_rs1, id_rs2  in  REG_ADDR_W  ID source registers.
REQ-008 Port: id_use_rs1, id_use_rs2  in  1  source actually read.
REQ-009 Port: id_rd  in  REG_ADDR_W  ID destination register.
REQ-010 Port: id_reg_write, id_mem_read  in  1  ID writes rd / ID is a load.
REQ-011 Port: stall  out  1  hold PC and IF/ID this cycle (combinational).
REQ-012 Port: fwd_a_sel, fwd_b_sel  out  2  select for EX operand muxes (registered).
REQ-013 Port: ex_bubble  out  1  EX holds an inserted bubble (registered).
REQ-014 Port: stall_count  out  16  saturating count of stall cycles.

Function
REQ-015 Select encoding SHALL be: 2'b00 register-file value, 2'b10 EX/MEM result, 2'b01 MEM/WB result; 2'b11 SHALL never be driven.
REQ-016 Block SHALL keep tracking stages EX, MEM, WB, each holding {valid, rd, reg_write, mem_read}.
REQ-017 With enable=1, each edge SHALL shift WB<=MEM, MEM<=EX, EX<=ID fields, or EX<=bubble (valid=0) when stall=1 or flush=1.
REQ-018 A stage is a producer only if valid=1, reg_write=1 and rd!=0.
REQ-019 stall SHALL be 1 when id_valid=1, flush=0, FSM in RUN, EX stage is a producer with mem_read=1, and (id_use_rs1 and id_rs1==EX.rd or id_use_rs2 and id_rs2==EX.rd).
REQ-020 Next fwd_x_sel SHALL be 2'b10 if id_use_rsx and EX producer rd matches; else 2'b01 if MEM producer rd matches; else 2'b00; latched when instruction enters EX (1-cycle latency, valid during its EX cycle).
REQ-021 EX producer match SHALL take priority over MEM match.
REQ-022 When a bubble enters EX, fwd_a_sel, fwd_b_sel SHALL load 2'b00 and ex_bubble SHALL load 1; otherwise ex_bubble loads 0.
REQ-023 FSM states RUN and STALL: RUN->STALL on stall=1 with enable=1; STALL->RUN on next enabled edge; in STALL, stall SHALL be 0 (load now in MEM, forwarded via 2'b01 path).
REQ-024 flush=1 SHALL force stall=0 and return FSM to RUN.
REQ-025 enable=0 SHALL hold all registers and outputs; stall stays combinational from held state.
REQ-026 stall_count SHALL increment on each enabled edge with stall=1, saturating at 16'hFFFF.

Reset
REQ-027 arst_n=0 SHALL immediately set all stage valids 0, FSM RUN, fwd_a_sel=fwd_b_sel=2'b00, ex_bubble=0, stall_count=0, hence stall=0.
REQ-028 Reset mid-stall SHALL abandon the stall; first post-reset instruction sees no producers.

Structure
REQ-029 Select codes (SEL_RF, SEL_EXMEM, SEL_MEMWB) and FSM state encoding SHALL live in a shared package used by the datapath muxes.
REQ-030 One sub-module, fwd_compare, SHALL compute a single operand select from rs, use, and EX/MEM stage fields; instantiated twice.

Verification
REQ-031 add x5 then add x6,x5,x1 back-to-back -> no stall, fwd_a_sel=2'b10 during consumer EX.
REQ-032 add x5; nop; sub x7,x1,x5 -> fwd_b_sel=2'b01, stall=0.
REQ-033 lw x5 then add x6,x5,x5 -> stall=1 one cycle, ex_bubble=1, then fwd_a_sel=fwd_b_sel=2'b01, stall_count=1.
REQ-034 add x0 then add x6,x0,x0 -> selects 2'b00; add x5,add x5,add x6,x5 -> 2'b10 (priority).
REQ-035 lw x5 + dependent with flush=1 -> stall=0, bubble enters EX, selects 2'b00.
REQ-036 enable=0 for 3 cycles mid-stall, then arst_n pulse -> outputs frozen, then all reset values.
